// File: rtl/uart_rx_fifo.sv
// UART receiver (LSB-first frames) feeding a synchronous receive FIFO with error pulses.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits and enable parity_err.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    done,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    overflow
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_WIDTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    if (CLKS_PER_BIT < 4) begin : g_chk_baud
        $error("CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
        $error("DATA_WIDTH must be 5..9");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [CW-1:0]         clk_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  push;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= StIdle;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            push      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            clk_cnt <= clk_cnt + 1'b1;
            unique case (state)
                StIdle: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= StStart;
                end
                StStart: begin
                    // Mid-start resample rejects short low glitches.
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        par_bad <= ((^shreg) ^ rx_s) != PARITY_ODD[0];
                        state   <= StStop;
                    end
                end
`endif
                StStop: begin
                    // Back to idle straight after the mid-stop sample.
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt   <= '0;
                        state     <= StIdle;
                        frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                        push       <= rx_s && !par_bad;
                        parity_err <= par_bad;
`else
                        push       <= rx_s;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count_next;
    logic                  pop;
    logic                  wr;

    assign pop = r_en && !empty;
    // A full FIFO still takes the word when a pop frees a slot in the same cycle.
    assign wr  = push && (!full || pop);

    always_comb begin
        count_next = count;
        if (wr && !pop) begin
            count_next = count + 1'b1;
        end else if (!wr && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !rst) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done     <= pop;
            overflow <= push && !wr;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated synchronous receive FIFO and error/status reporting. Sits between the external serial `rx` pin and the downstream AXI/DDR write path. It deserialises LSB-first frames of configurable width, optionally checks parity, and buffers good words. The consumer drains them with a registered pop handshake.

## Interface
- `DATA_WIDTH`, 8: bits per frame (5–9)
- `CLK_FREQ`, 100_000_000: system clock in Hz
- `BAUD_RATE`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ/BAUD_RATE` (integer division, must be ≥ 4)
- `DEPTH`, 1024: FIFO entries; power of two, ≥ 2
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored unless parity is compiled in

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `rx` in 1: asynchronous serial input, idle high
- `r_en` in 1: pop request
- `data_out` out DATA_WIDTH: popped word, held until next pop
- `done` out 1: one-cycle pulse, `data_out` updated
- `empty` out 1: FIFO holds 0 words
- `full` out 1: FIFO holds DEPTH words
- `count` out $clog2(DEPTH)+1: words held
- `frame_err` out 1: one-cycle pulse, stop bit sampled low
- `parity_err` out 1: one-cycle pulse, parity mismatch (tied 0 when parity is compiled out)
- `overflow` out 1: one-cycle pulse, good word dropped because FIFO full

## Operation
- `rx` passes through a 2-flop synchroniser. All decisions use the synchronised value `rx_s`.
- Bit counter counts 0..CLKS_PER_BIT-1. The bit index counts 0..DATA_WIDTH-1.
- RX FSM states: IDLE, START, DATA, PARITY (present only when compiled in), STOP.
  - IDLE: on `rx_s`==0 go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1, resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA and clear the counter.
  - DATA: at count CLKS_PER_BIT-1, shift `rx_s` into bit[index] (LSB first). After the last bit, go to PARITY or STOP.
  - PARITY: sample one bit period later. Check XOR(data, parity bit) == PARITY_ODD.
  - STOP: sample one bit period later.
    - If the sample is 1 and parity is good: push the word.
    - If the sample is 0: pulse `frame_err` and discard the word.
    - If parity is bad (stop bit good): pulse `parity_err` and discard the word.
    - If both fail, pulse both and discard.
    - Return to IDLE immediately after the mid-stop sample, so back-to-back frames are accepted.
- FIFO: circular buffer with $clog2(DEPTH)-bit read/write pointers that wrap naturally, plus a separate `count`.
  - Push is accepted if `!full`, or if `full` and a pop occurs in the same cycle. Otherwise the word is dropped and `overflow` pulses.
  - Pop when `r_en` && `!empty`: `data_out` <= mem[rd_ptr] and `done`=1 the next cycle. Pop while empty is ignored: no `done`, and `data_out` is unchanged.
  - Simultaneous push and pop: both happen and `count` is unchanged.
  - `r_en` held high drains one word per cycle.
- Reset values: FSM = IDLE; pointers and `count` = 0; `empty`=1; `full`=0; `data_out`=0. `done`, `frame_err`, `parity_err` and `overflow` = 0. Synchroniser flops = 1.
- Reset mid-frame aborts the frame with no push and no error pulse. FIFO contents are logically discarded.

## Timing
- Synchroniser latency: 2 cycles.
- Push strobe occurs 1 cycle after the stop-bit sample. `count`, `empty` and `full` reflect the push on the following edge.
- Start-edge-to-push latency: 2 + CLKS_PER_BIT/2 + (DATA_WIDTH + P + 1)·CLKS_PER_BIT + 1 cycles, where P = 1 with parity compiled in, else 0.
- Pop latency: 1 cycle from `r_en` to `done`/`data_out`.
- Error pulses coincide with the cycle the push would have occurred.
- `count`, `empty` and `full` are registered.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state and checker exist, and `parity_err` is live. A frame is start + DATA_WIDTH + parity + stop.
- Macro absent: no parity bit is expected, the PARITY state is removed, and `parity_err` is constant 0.

## Test plan
All scenarios use defaults: CLKS_PER_BIT = 868, no parity unless noted.

- Send 0xAA, 0x55, 0x35, 0x09 with no `r_en` -> `count`=4; then four 1-cycle `r_en` pulses -> `data_out` 0xAA, 0x55, 0x35, 0x09, each with a 1-cycle `done`; `empty`=1 after the last.
- 0x3C sent with its stop bit driven 0 -> `frame_err` pulse; `count` stays 0. Next frame 0x81 -> pushed normally.
- DEPTH=4: send 5 frames 0x01–0x05 -> `full`=1 after the fourth; `overflow` pulses on the fifth; reads return 0x01–0x04.
- A 200-cycle low glitch on idle `rx` -> no push and no error pulse; FSM back in IDLE.
- `r_en`=1 while empty -> no `done`, `data_out` unchanged. Pop on the exact push cycle with `count`=1 -> `count` stays 1.
- With `UART_RX_PARITY_EN`, PARITY_ODD=0: send 0x07 with parity bit 1 -> pushed. Send 0x07 with parity bit 0 -> `parity_err` pulse, not pushed.
- `rst` asserted mid-DATA -> all outputs return to their reset values; a following 0xC3 frame is received correctly.
